// File: rtl/sprite_anim_ctrl.sv
// Animation controller for a sprite. It runs a free-running step timer and a STAND/RUN/JUMP FSM
// that track which way the character faces and which sprite frame to show.
// Latency: keys sampled at edge N show up in char_state after edge N. frame_tick is decoded from the tick counter.
// Backpressure: none. Inputs are level-sampled every cycle and the outputs update every cycle.
module sprite_anim_ctrl #(
   parameter int TICK_DIV   = 6000000,
   parameter int JUMP_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_jump,
   input  logic       on_ground,
   output logic [2:0] char_state,
   output logic [1:0] frame_idx,
   output logic       frame_tick,
   output logic       jump_active
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int JW = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS + 1) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [JW-1:0] JCNT_MAX = JW'(JUMP_TICKS);

   // State encoding doubles as the mode field of char_state
   typedef enum logic [1:0] {
      ST_STAND = 2'b00,
      ST_RUN   = 2'b01,
      ST_JUMP  = 2'b10
   } state_t;

   logic [TW-1:0] r_tick_cnt;
   logic [3:0]    r_step;
   logic [JW-1:0] r_jump_cnt;
   logic          r_jump_prev;
   state_t        r_state;
   logic          r_facing;
   logic [1:0]    r_frame_idx;
   logic          r_jump_active;

   logic          w_move;
   logic          w_jump_go;
   logic          w_mode_chg;
   logic [3:0]    w_step_nxt;
   state_t        w_next_state;

   assign w_move     = key_left ^ key_right;
   // Rising edge of the jump key, honoured only when standing on something
   assign w_jump_go  = key_jump & ~r_jump_prev & on_ground;
   assign w_mode_chg = (w_next_state != r_state);
   assign w_step_nxt = r_step + 4'd1;
   assign frame_tick = (r_tick_cnt == TICK_MAX);

   assign char_state  = {r_state, r_facing};
   assign frame_idx   = r_frame_idx;
   assign jump_active = r_jump_active;

   // Free-running animation tick divider; mode changes never disturb it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if (frame_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   // Next-mode decision: a qualified jump beats run/stand, and JUMP waits for min ticks plus ground
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_STAND: begin
            if (w_jump_go)   w_next_state = ST_JUMP;
            else if (w_move) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (w_jump_go)    w_next_state = ST_JUMP;
            else if (!w_move) w_next_state = ST_STAND;
         end
         ST_JUMP: begin
            if ((r_jump_cnt == JCNT_MAX) && on_ground)
               w_next_state = w_move ? ST_RUN : ST_STAND;
         end
         default: w_next_state = ST_STAND;
      endcase
   end

   // FSM state plus registered outputs: step, frame select, jump counter, facing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_STAND;
         r_facing      <= 1'b1;
         r_step        <= 4'd0;
         r_frame_idx   <= 2'd0;
         r_jump_cnt    <= '0;
         r_jump_prev   <= 1'b0;
         r_jump_active <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_jump_prev   <= key_jump;
         r_jump_active <= (w_next_state == ST_JUMP);
         if (w_move) begin
            r_facing <= key_right;
         end
         if (w_mode_chg) begin
            // A mode change restarts the animation and wins over a coincident tick
            r_step      <= 4'd0;
            r_frame_idx <= 2'd0;
            r_jump_cnt  <= '0;
         end else if (frame_tick) begin
            r_step      <= w_step_nxt;
            r_frame_idx <= (r_state == ST_JUMP) ? 2'd0 : w_step_nxt[3:2];
            if ((r_state == ST_JUMP) && (r_jump_cnt != JCNT_MAX)) begin
               r_jump_cnt <= r_jump_cnt + JW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Bench for sprite_anim_ctrl. It runs directed scenarios followed by randomized key and ground activity.
// The outputs are compared every cycle against an integer-level behavioural model.
// Inputs are driven on the falling edge, and outputs are sampled 1 time unit after the rising edge.
module tb_sprite_anim_ctrl;

   localparam int TD = 4;
   localparam int JT = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       kl = 1'b0, kr = 1'b0, kj = 1'b0, og = 1'b1;
   logic [2:0] char_state;
   logic [1:0] frame_idx;
   logic       frame_tick;
   logic       jump_active;

   int checks = 0;
   int failures = 0;

   // Reference model state: cycles since reset, mode 0/1/2, facing, step 0..15, jump ticks
   int m_cyc, m_mode, m_facing, m_step, m_jcnt;
   bit m_pj;

   sprite_anim_ctrl #(.TICK_DIV(TD), .JUMP_TICKS(JT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_left   (kl),
      .key_right  (kr),
      .key_jump   (kj),
      .on_ground  (og),
      .char_state (char_state),
      .frame_idx  (frame_idx),
      .frame_tick (frame_tick),
      .jump_active(jump_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function void model_reset();
      m_cyc = 0; m_mode = 0; m_facing = 1; m_step = 0; m_jcnt = 0; m_pj = 1'b0;
   endfunction

   function automatic void model_edge(input bit l, input bit r, input bit j, input bit g);
      bit tick;
      bit mv;
      bit je;
      int nm;
      tick = (m_cyc % TD) == TD - 1;
      mv   = l ^ r;
      je   = j && !m_pj;
      nm   = m_mode;
      case (m_mode)
         0:       begin if (je && g) nm = 2; else if (mv) nm = 1; end
         1:       begin if (je && g) nm = 2; else if (!mv) nm = 0; end
         default: begin if (m_jcnt == JT && g) nm = mv ? 1 : 0; end
      endcase
      if (nm != m_mode) begin
         m_step = 0;
         m_jcnt = 0;
      end else if (tick) begin
         m_step = (m_step + 1) % 16;
         if (m_mode == 2 && m_jcnt < JT) m_jcnt++;
      end
      if (l && !r) m_facing = 0;
      else if (r && !l) m_facing = 1;
      m_mode = nm;
      m_pj   = j;
      m_cyc++;
   endfunction

   // One clock: called and returning at a falling edge
   task automatic cyc(input bit l, input bit r, input bit j, input bit g);
      logic [2:0] exp_cs;
      kl = l; kr = r; kj = j; og = g;
      check("frame_tick", frame_tick, ((m_cyc % TD) == TD - 1) ? 1 : 0);
      @(posedge clk);
      model_edge(l, r, j, g);
      #1;
      exp_cs = {m_mode[1:0], m_facing[0]};
      check("char_state", char_state, exp_cs);
      check("frame_idx", frame_idx, (m_mode == 2) ? 0 : m_step / 4);
      check("jump_active", jump_active, (m_mode == 2) ? 1 : 0);
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_char_state", char_state, 3'b001);
      check("rst_frame_idx", frame_idx, 2'd0);
      check("rst_frame_tick", frame_tick, 1'b0);
      check("rst_jump_active", jump_active, 1'b0);
      rst_n = 1'b1;

      // Idle: stand right, frames advance every 16 cycles
      repeat (40) cyc(0, 0, 0, 1);

      // Run left, then stop
      cyc(1, 0, 0, 1);
      check("run_left", char_state, 3'b010);
      check("run_step_clr", dut.r_step, 4'd0);
      repeat (5) cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
      check("stand_left", char_state, 3'b000);
      check("stand_frame0", frame_idx, 2'd0);

      // Grounded jump facing right; holding the key must not retrigger
      cyc(0, 1, 1, 1);
      check("jump_enter", char_state, 3'b101);
      check("jump_active_on", jump_active, 1'b1);
      repeat (14) cyc(0, 0, 1, 1);
      check("jump_exit", char_state, 3'b001);
      check("jump_active_off", jump_active, 1'b0);

      // Airborne press ignored; then a jump that stays up while off the ground
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
      check("air_jump_ignored", char_state, 3'b001);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 1);
      check("jump2_enter", char_state, 3'b101);
      repeat (15) cyc(0, 0, 0, 0);
      check("jump_hold_air", char_state[2:1], 2'b10);
      cyc(0, 1, 0, 1);
      check("land_run_right", char_state, 3'b011);

      // Both keys while running right: stand, facing held; align change with a tick
      for (int i = 0; i < TD; i++) begin
         if ((m_cyc % TD) == TD - 1) break;
         cyc(0, 1, 0, 1);
      end
      check("aligned_tick", frame_tick, 1'b1);
      cyc(1, 1, 0, 1);
      check("both_keys_stand", char_state, 3'b001);
      check("tick_vs_clear", dut.r_step, 4'd0);

      // Reset asserted mid-jump while facing left takes effect without a clock
      cyc(1, 0, 0, 1);
      cyc(1, 0, 1, 1);
      cyc(1, 0, 1, 1);
      check("jump_left", char_state, 3'b100);
      #2;
      rst_n = 1'b0;
      kl = 1'b0; kj = 1'b0;
      #1;
      check("async_rst_cs", char_state, 3'b001);
      check("async_rst_ja", jump_active, 1'b0);
      check("async_rst_fi", frame_idx, 2'd0);
      check("async_rst_ft", frame_tick, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (TD + 2) cyc(0, 0, 0, 1);

      // Randomized activity
      for (int n = 0; n < 3000; n++) begin
         bit l, r, j, g;
         l = ($urandom % 4) == 0;
         r = ($urandom % 4) == 0;
         j = ($urandom % 3) == 0;
         g = ($urandom % 5) != 0;
         cyc(l, r, j, g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
